param_dmem: RTL

Parametrised data-memory model for the Sodor core harnesses; successor to the fixed single-cycle DMEM. It sits beside the core in the top-level wrapper on the dmem request/response bus and adds configurable depth, configurable response latency with a ready/valid handshake, sub-word load/store formatting and misaligned-access detection. It lets the same core be exercised against both asynchronous and multi-cycle memory without changing the core.

---
 rtl/param_dmem_pkg.sv | 20 ++
 rtl/param_dmem_if.sv | 38 +++
 rtl/param_dmem_lane_fmt.sv | 45 ++++
 rtl/param_dmem.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/param_dmem_pkg.sv
// Shared constants and FSM state type for the parametrised data memory.
// Holds the memory-function and access-type encodings used on the dmem bus.
package dmem_pkg;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/param_dmem_if.sv
// dmem request/response bus between the core (master) and the memory model (slave).
interface param_dmem_if;

  logic [31:0] dmem_in_io_dmem_req_bits_addr;
  logic [31:0] dmem_in_io_dmem_req_bits_data;
  logic        dmem_in_io_dmem_req_bits_fcn;
  logic [2:0]  dmem_in_io_dmem_req_bits_typ;
  logic        dmem_in_io_dmem_req_valid;
  logic        dmem_ou_io_dmem_req_ready;
  logic [31:0] dmem_ou_io_dmem_resp_bits_data;
  logic        dmem_ou_io_dmem_resp_valid;
  logic        dmem_ou_misalign_err;

  modport master (
    output dmem_in_io_dmem_req_bits_addr,
    output dmem_in_io_dmem_req_bits_data,
    output dmem_in_io_dmem_req_bits_fcn,
    output dmem_in_io_dmem_req_bits_typ,
    output dmem_in_io_dmem_req_valid,
    input  dmem_ou_io_dmem_req_ready,
    input  dmem_ou_io_dmem_resp_bits_data,
    input  dmem_ou_io_dmem_resp_valid,
    input  dmem_ou_misalign_err
  );

  modport slave (
    input  dmem_in_io_dmem_req_bits_addr,
    input  dmem_in_io_dmem_req_bits_data,
    input  dmem_in_io_dmem_req_bits_fcn,
    input  dmem_in_io_dmem_req_bits_typ,
    input  dmem_in_io_dmem_req_valid,
    output dmem_ou_io_dmem_req_ready,
    output dmem_ou_io_dmem_resp_bits_data,
    output dmem_ou_io_dmem_resp_valid,
    output dmem_ou_misalign_err
  );

endinterface

// File: rtl/param_dmem_lane_fmt.sv
// Byte-lane formatter: store strobe/replication, load extraction/extension and
// misalignment detection for one access. Purely combinational.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] req_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  strb,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rd_word[{addr_lo, 3'b000} +: 8];
  assign half_v = rd_word[{addr_lo[1], 4'b0000} +: 16];

  // Unlisted type codes behave as a full word access.
  always_comb begin
    strb     = '1;
    wr_word  = req_data;
    ld_data  = rd_word;
    misalign = (addr_lo != 2'b00);
    case (typ)
      MT_B, MT_BU: begin
        strb     = 4'b0001 << addr_lo;
        wr_word  = {4{req_data[7:0]}};
        ld_data  = (typ == MT_B) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
        misalign = 1'b0;
      end
      MT_H, MT_HU: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{req_data[15:0]}};
        ld_data  = (typ == MT_H) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
        misalign = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_dmem.sv
// Parametrised data memory: configurable depth and response latency, sub-word
// formatting, sticky misalign flag. Optional trace ports: PARAM_DMEM_TRACE_EN.
module param_dmem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 0
) (
  input  logic        clock,
  input  logic        reset,
  param_dmem_if.slave dmem
`ifdef PARAM_DMEM_TRACE_EN
  ,
  output logic        trace_valid,
  output logic        trace_we,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_strb
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [3:0]    strb;
  logic [31:0]   wr_word;
  logic [31:0]   ld_data;
  logic          misalign;
  logic          req_v;
  logic          is_wr;
  logic          req_ready;
  logic          accept;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          err_q;
  logic          unused_addr;

  assign req_v       = dmem.dmem_in_io_dmem_req_valid;
  assign is_wr       = (dmem.dmem_in_io_dmem_req_bits_fcn == M_XWR);
  assign idx         = dmem.dmem_in_io_dmem_req_bits_addr[AW+1:2];
  assign unused_addr = ^dmem.dmem_in_io_dmem_req_bits_addr[31:AW+2];
  assign rd_word     = mem[idx];
  assign accept      = req_v && req_ready;

  dmem_lane_fmt u_fmt (
    .typ      (dmem.dmem_in_io_dmem_req_bits_typ),
    .addr_lo  (dmem.dmem_in_io_dmem_req_bits_addr[1:0]),
    .req_data (dmem.dmem_in_io_dmem_req_bits_data),
    .rd_word  (rd_word),
    .strb     (strb),
    .wr_word  (wr_word),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  // Array contents survive reset.
  always_ff @(posedge clock) begin
    if (accept && is_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                   err_q <= 1'b0;
    else if (accept && misalign) err_q <= 1'b1;
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign req_ready  = 1'b1;
      assign resp_valid = req_v;
      assign resp_data  = ld_data;
    end else begin : g_seq
      localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

      dmem_state_e state_q, state_d;
      logic [3:0]  cnt_q, cnt_d;
      logic [31:0] data_q, data_d;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          data_q  <= data_d;
        end
      end

      // Request valid is used directly in branches where ready is already 1,
      // keeping ready free of a combinational path back through accept.
      always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
          IDLE: begin
            req_ready = 1'b1;
            if (req_v) begin
              state_d = WAIT;
              cnt_d   = CNT_LOAD;
              data_d  = is_wr ? '0 : ld_data;
            end
          end
          WAIT: begin
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end else begin
              resp_valid = 1'b1;
              req_ready  = 1'b1;
              if (req_v) begin
                cnt_d  = CNT_LOAD;
                data_d = is_wr ? '0 : ld_data;
              end else begin
                state_d = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
        resp_data = resp_valid ? data_q : '0;
      end
    end
  endgenerate

  assign dmem.dmem_ou_io_dmem_req_ready      = req_ready;
  assign dmem.dmem_ou_io_dmem_resp_valid     = resp_valid;
  assign dmem.dmem_ou_io_dmem_resp_bits_data = resp_data;
  assign dmem.dmem_ou_misalign_err           = err_q;

`ifdef PARAM_DMEM_TRACE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_we    <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
      trace_strb  <= '0;
    end else begin
      trace_valid <= accept;
      if (accept) begin
        trace_we   <= is_wr;
        trace_addr <= dmem.dmem_in_io_dmem_req_bits_addr;
        trace_data <= is_wr ? dmem.dmem_in_io_dmem_req_bits_data : ld_data;
        trace_strb <= strb;
      end
    end
  end
`endif

endmodule
